// File: rtl/div_arb_pkg.sv
// Shared constants and FSM encoding for the divider-sharing arbiter.
package div_arb_pkg;
  localparam int DW   = 16;
  localparam int IDW  = 2;
  localparam int CNTW = 16;
  localparam logic [DW-1:0] QERR = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BLANK,
    S_WAIT,
    S_RESP
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching from last+1.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] first;
  int             j;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    first   = (int'(last) >= NREQ - 1) ? '0 : last + 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(first) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && ((req >> j) & NREQ'(1)) != '0) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider between NREQ requesters; resolves divide-by-zero
// and divider hangs locally and returns tagged results.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_y,
  output logic [DW-1:0]      rsp_rem,
  output logic               rsp_err,
  output logic               div_start,
  output logic [DW-1:0]      div_a,
  output logic [DW-1:0]      div_b,
  input  logic               div_done,
  input  logic [DW-1:0]      div_y,
  input  logic [DW-1:0]      div_rem
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            div_start_q, div_start_d;
  logic [DW-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   y_q, y_d, rem_q, rem_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_y_q, rsp_y_d, rsp_rem_q, rsp_rem_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [DW-1:0]   a_sel, b_sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign a_sel     = req_a[DW*int'(gnt_idx) +: DW];
  assign b_sel     = req_b[DW*int'(gnt_idx) +: DW];
  // Grant is only visible while idle and out of reset, so a reset cycle never accepts.
  assign req_ready = (state_q == S_IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    div_start_d = 1'b0;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    id_d        = id_q;
    y_d         = y_q;
    rem_d       = rem_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gnt_any) begin
          last_d = gnt_idx;
          id_d   = gnt_idx;
          if (b_sel == '0) begin
            y_d     = QERR;
            rem_d   = a_sel;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            div_a_d     = a_sel;
            div_b_d     = b_sel;
            div_start_d = 1'b1;
            state_d     = S_START;
          end
        end
      end
      S_START: state_d = S_BLANK;
      // One dead cycle so a done level left from the previous divide is not taken.
      S_BLANK: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done) begin
          y_d     = div_y;
          rem_d   = div_rem;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_d == CNTW'(TIMEOUT)) begin
          y_d     = QERR;
          rem_d   = QERR;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_y_d     = y_q;
        rsp_rem_d   = rem_q;
        rsp_err_d   = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      id_q        <= '0;
      y_q         <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      div_start_q <= div_start_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      id_q        <= id_d;
      y_q         <= y_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_rem   = rsp_rem_q;
  assign rsp_err   = rsp_err_q;

endmodule
